// File: rtl/tt_um_big_ben_fr_implies_bist.sv
// Built-in self-test tester for an external 4-bit IMPLIES gate (Y = ~A | B).
// Sweeps all 256 {B,A} vectors out on uio_out. Each response arriving on
// ui_in[7:4] LATENCY cycles later is compared with the internally predicted
// value. Mismatches are counted (saturating at 15), and the result is
// reported as done/pass/fail on uo_out.
// Optional build macro: IMPLIES_BIST_LOOPBACK_EN. When defined, the response
// comes from an internal IMPLIES model that sees uio_out through the same
// LATENCY-deep delay. ui_in[2] then inverts response bit 0.
module tt_um_big_ben_fr_implies_bist #(
  parameter int LATENCY = 2  // vector-to-response delay in cycles, legal 1..4
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic                       r_start_q;
  logic [7:0]                 r_cnt;
  logic [3:0]                 r_err;
  logic [LATENCY-1:0]         r_pipe_vld;
  logic [LATENCY-1:0][3:0]    r_pipe_exp;

  logic       w_start_edge;
  logic       w_abort;
  logic       w_busy;
  logic       w_launch;
  logic [3:0] w_push_exp;
  logic [3:0] w_resp;
  logic       w_mismatch;
  logic [7:0] w_uio_out;

  assign w_start_edge = ui_in[0] & ~r_start_q;
  assign w_abort      = ui_in[1];
  assign w_busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_launch     = ((r_state == S_IDLE) || (r_state == S_DONE)) && w_start_edge;
  assign w_push_exp   = ~r_cnt[3:0] | r_cnt[7:4];
  assign w_uio_out    = (r_state == S_RUN) ? r_cnt : ((r_state == S_DRAIN) ? 8'hFF : 8'h00);

`ifdef IMPLIES_BIST_LOOPBACK_EN
  logic [LATENCY-1:0][7:0] r_pipe_vec;
  logic                    w_unused;

  // Loopback gate model: delay the driven vector exactly like the expectation pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vec <= '0;
    end else if (ena) begin
      if (w_abort || w_launch) begin
        r_pipe_vec <= '0;
      end else if (w_busy) begin
        r_pipe_vec[0] <= w_uio_out;
        for (int i = 1; i < LATENCY; i++) begin
          r_pipe_vec[i] <= r_pipe_vec[i-1];
        end
      end
    end
  end

  assign w_resp   = (~r_pipe_vec[LATENCY-1][3:0] | r_pipe_vec[LATENCY-1][7:4]) ^ {3'b000, ui_in[2]};
  assign w_unused = ^{uio_in, ui_in[7:3]};
`else
  logic w_unused;

  assign w_resp   = ui_in[7:4];
  assign w_unused = ^{uio_in, ui_in[3:2]};
`endif

  assign w_mismatch = w_busy && r_pipe_vld[LATENCY-1] && (w_resp != r_pipe_exp[LATENCY-1]);

  // FSM state register; frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (ena) begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. Abort beats everything, including a same-cycle start.
  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (w_start_edge) w_state_next = S_RUN;
        S_RUN:          if (r_cnt == 8'hFF) w_state_next = S_DRAIN;
        S_DRAIN:        if (r_cnt == 8'(LATENCY - 1)) w_state_next = S_DONE;
        default:        w_state_next = S_IDLE;
      endcase
    end
  end

  // Datapath: start sampler, vector/drain counter, expectation pipe and error counter.
  // r_cnt wraps to 0 when leaving RUN, so it also counts the drain cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q  <= 1'b0;
      r_cnt      <= 8'h00;
      r_err      <= 4'h0;
      r_pipe_vld <= '0;
      r_pipe_exp <= '0;
    end else if (ena) begin
      r_start_q <= ui_in[0];
      if (w_abort || w_launch) begin
        r_cnt      <= 8'h00;
        r_err      <= 4'h0;
        r_pipe_vld <= '0;
        r_pipe_exp <= '0;
      end else if (w_busy) begin
        r_cnt         <= r_cnt + 8'd1;
        r_pipe_vld[0] <= (r_state == S_RUN);
        r_pipe_exp[0] <= (r_state == S_RUN) ? w_push_exp : 4'h0;
        for (int i = 1; i < LATENCY; i++) begin
          r_pipe_vld[i] <= r_pipe_vld[i-1];
          r_pipe_exp[i] <= r_pipe_exp[i-1];
        end
        if (w_mismatch && (r_err != 4'hF)) begin
          r_err <= r_err + 4'd1;
        end
      end
    end
  end

  assign uio_out = w_uio_out;
  assign uio_oe  = w_busy ? 8'hFF : 8'h00;
  assign uo_out  = {r_err,
                    (r_state == S_DONE) && (r_err != 4'h0),
                    (r_state == S_DONE) && (r_err == 4'h0),
                    (r_state == S_DONE),
                    w_busy};

endmodule

// File: tb/tb_tt_um_big_ben_fr_implies_bist.sv
// Randomized self-checking bench for tt_um_big_ben_fr_implies_bist.
// An external IMPLIES gate model can be given stuck masks and single-vector
// flips. Expected results come from counting bad vectors over the whole space.
module tb_tt_um_big_ben_fr_implies_bist;

  localparam int LAT = 2;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [3:0] ctl;
  logic [3:0] resp;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks;
  int failures;

  // Gate fault configuration: y = ((~a|b) & and_m | or_m) ^ (flip_x on vector flip_v)
  logic [3:0] and_m;
  logic [3:0] or_m;
  logic       flip_en;
  logic [7:0] flip_v;
  logic [3:0] flip_x;

  logic [7:0] g_d1;
  logic [7:0] g_d2;

  assign ui_in = {resp, ctl};

  tt_um_big_ben_fr_implies_bist #(.LATENCY(LAT)) dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] gate_fn(input logic [7:0] v);
    logic [3:0] y;
    y = ((~v[3:0] | v[7:4]) & and_m) | or_m;
    if (flip_en && (v == flip_v)) y = y ^ flip_x;
    return y;
  endfunction

  // External gate: two-stage delay sharing the system clock enable.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_d1 <= 8'h00;
      g_d2 <= 8'h00;
    end else if (ena) begin
      g_d1 <= uio_out;
      g_d2 <= g_d1;
    end
  end

  always_comb resp = gate_fn(g_d2);

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: count vectors whose gate output differs from the IMPLIES truth table.
  function automatic logic [7:0] expected_uo();
    int bad;
    int sat;
    bit ok;
    logic [3:0] y;
    bad = 0;
    for (int v = 0; v < 256; v++) begin
      y  = gate_fn(8'(v));
      ok = 1'b1;
      for (int b = 0; b < 4; b++) begin
        if (y[b] != (((v >> b) & 1) == 0 || ((v >> (b + 4)) & 1) == 1)) ok = 1'b0;
      end
      if (!ok) bad++;
    end
    sat = (bad > 15) ? 15 : bad;
    return {4'(sat), bad != 0, bad == 0, 1'b1, 1'b0};
  endfunction

  task automatic set_gate(input logic [3:0] am, input logic [3:0] om, input bit fe,
                          input logic [7:0] fv, input logic [3:0] fx);
    and_m = am; or_m = om; flip_en = fe; flip_v = fv; flip_x = fx;
  endtask

  // One run from an idle/done state. abort_at/ena_at < 0 disable those events.
  task automatic do_run(input string name, input int abort_at, input int ena_at,
                        input bit hold_start, input bit retrig);
    int k, busy_cnt, done_k, seq_err, oe_err, hold_err;
    logic [7:0] exp_uo;
    exp_uo   = expected_uo();
    k        = 0;
    busy_cnt = 0;
    done_k   = -1;
    seq_err  = 0;
    oe_err   = 0;
    hold_err = 0;
    @(negedge clk);
    ctl[0] = 1'b1;
    ctl[3] = 1'($urandom);
    ctl[2] = 1'($urandom);
    @(posedge clk);
    while (k < 400 && done_k < 0) begin
      @(negedge clk);
      k++;
      if (k == 1 && !hold_start) ctl[0] = 1'b0;
      if (retrig) begin
        if (k == 50 || k == 257) ctl[0] = 1'b1;
        if (k == 51 || k == 258) ctl[0] = 1'b0;
      end
      if (uo_out[0]) begin
        busy_cnt++;
        if (uio_oe != 8'hFF) oe_err++;
        if (k <= 256 && uio_out != 8'(k - 1)) seq_err++;
      end else if (uio_oe != 8'h00) begin
        oe_err++;
      end
      if (k <= 256 && !uo_out[0]) seq_err++;
      if (uo_out[1]) done_k = k;
      if (abort_at >= 0 && k <= 256 && uio_out == 8'(abort_at)) begin
        ctl[1] = 1'b1;
        @(negedge clk);
        check_value({name, "_abort_uo"}, 32'(uo_out), 32'h00);
        check_value({name, "_abort_oe"}, 32'(uio_oe), 32'h00);
        check_value({name, "_abort_vec"}, 32'(uio_out), 32'h00);
        ctl[1] = 1'b0;
        ctl[0] = 1'b0;
        $display("run %s: aborted at vector 0x%02h", name, abort_at);
        return;
      end
      if (ena_at >= 0 && k <= 256 && uio_out == 8'(ena_at)) begin
        ena = 1'b0;
        repeat (10) begin
          @(negedge clk);
          if (uio_out != 8'(ena_at) || !uo_out[0]) hold_err++;
        end
        ena = 1'b1;
        check_value({name, "_ena_hold"}, 32'(hold_err), 32'd0);
      end
    end
    check_value({name, "_vec_seq"}, 32'(seq_err), 32'd0);
    check_value({name, "_oe"}, 32'(oe_err), 32'd0);
    check_value({name, "_busy_cycles"}, 32'(busy_cnt), 32'(256 + LAT));
    check_value({name, "_done_cycle"}, 32'(done_k), 32'(257 + LAT));
    check_value({name, "_result"}, 32'(uo_out), 32'(exp_uo));
    $display("run %s: uo_out=0x%02h expected=0x%02h busy=%0d done_at=%0d",
             name, uo_out, exp_uo, busy_cnt, done_k);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ena      = 1'b1;
    ctl      = 4'h0;
    uio_in   = 8'h00;
    set_gate(4'hF, 4'h0, 1'b0, 8'h00, 4'h0);

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_value("rst_uo", 32'(uo_out), 32'h00);
    check_value("rst_oe", 32'(uio_oe), 32'h00);
    check_value("rst_vec", 32'(uio_out), 32'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_value("idle_uo", 32'(uo_out), 32'h00);
    check_value("idle_oe", 32'(uio_oe), 32'h00);
    $display("reset: uo_out=0x%02h uio_oe=0x%02h uio_out=0x%02h", uo_out, uio_oe, uio_out);

    // Good gate, then stuck Y[3]=0, then a single flipped vector (err=1).
    do_run("good", -1, -1, 1'b0, 1'b0);
    set_gate(4'b0111, 4'h0, 1'b0, 8'h00, 4'h0);
    do_run("stuck3", -1, -1, 1'b0, 1'b0);
    check_value("stuck3_uo", 32'(uo_out), 32'hFA);
    set_gate(4'hF, 4'h0, 1'b1, 8'(32'($urandom_range(0, 255))), 4'(32'($urandom_range(1, 15))));
    do_run("oneflip", -1, -1, 1'b0, 1'b0);
    check_value("oneflip_uo", 32'(uo_out), 32'h1A);

    // Random gate faults.
    for (int i = 0; i < 4; i++) begin
      set_gate(4'($urandom) | 4'($urandom), 4'($urandom) & 4'($urandom), 1'($urandom),
               8'($urandom), 4'($urandom));
      do_run("random", -1, -1, 1'b0, 1'b0);
    end

    // Abort at 0x40, then a full run on a good gate.
    set_gate(4'hF, 4'h0, 1'b0, 8'h00, 4'h0);
    do_run("abort40", 8'h40, -1, 1'b0, 1'b0);
    do_run("after_abort", -1, -1, 1'b0, 1'b0);

    // Abort wins over a same-cycle start edge.
    @(negedge clk);
    ctl[0] = 1'b1;
    ctl[1] = 1'b1;
    @(negedge clk);
    check_value("abort_vs_start", 32'(uo_out), 32'h00);
    ctl = 4'h0;
    @(negedge clk);

    // ena drop at 0x80 with start held high through the run: exactly one run.
    do_run("ena_hold", -1, 8'h80, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check_value("single_run_uo", 32'(uo_out), 32'h06);
    check_value("single_run_oe", 32'(uio_oe), 32'h00);
    ctl[0] = 1'b0;

    // Start edges during RUN and DRAIN are ignored.
    set_gate(4'b1110, 4'h0, 1'b0, 8'h00, 4'h0);
    do_run("retrig", -1, -1, 1'b0, 1'b1);

    // Random abort point, followed by a full run.
    set_gate(4'hF, 4'h0, 1'b0, 8'h00, 4'h0);
    do_run("abort_rand", int'($urandom_range(0, 255)), -1, 1'b0, 1'b0);
    do_run("after_abort2", -1, -1, 1'b0, 1'b0);

    // Reset mid-run returns everything to reset values immediately.
    @(negedge clk);
    ctl[0] = 1'b1;
    @(negedge clk);
    ctl[0] = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_value("midrst_uo", 32'(uo_out), 32'h00);
    check_value("midrst_vec", 32'(uio_out), 32'h00);
    check_value("midrst_oe", 32'(uio_oe), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_value("postrst_uo", 32'(uo_out), 32'h00);
    $display("mid-run reset: uo_out=0x%02h uio_out=0x%02h", uo_out, uio_out);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
